// File: rtl/fcc_credit_return.sv
// Receive-side flit buffer for one router input port; returns one credit per dequeue after CREDIT_LAT cycles.
// Optional macro FCC_OVF_CHECK_EN adds a sticky ovf_err_o flag and a simulation check for dropped writes.
module fcc_credit_return #(
    parameter int FLIT_W     = 32,
    parameter int DEPTH      = 4,
    parameter int CREDIT_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flit_valid_i,
    input  logic [FLIT_W-1:0]            flit_data_i,
    output logic                         flit_valid_o,
    output logic [FLIT_W-1:0]            flit_data_o,
    input  logic                         flit_ready_i,
    output logic                         credit_incr_o,
`ifdef FCC_OVF_CHECK_EN
    output logic                         ovf_err_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0][FLIT_W-1:0] mem;
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;
    logic [OCC_W-1:0]             occ;
    logic [CREDIT_LAT-1:0]        crd_pipe;
    logic                         full, deq, wr, drop;

    assign full = (occ == OCC_W'(DEPTH));
    assign deq  = (occ != '0) & flit_ready_i;
    // A dequeue in the same cycle frees the slot, so a full buffer still accepts.
    assign wr   = flit_valid_i & (~full | deq);
    assign drop = flit_valid_i & full & ~deq;

    assign flit_valid_o  = (occ != '0);
    assign flit_data_o   = mem[rd_ptr];
    assign occupancy_o   = occ;
    assign credit_incr_o = crd_pipe[CREDIT_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= flit_data_i;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (deq)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr && !deq)
                occ <= occ + OCC_W'(1);
            else if (deq && !wr)
                occ <= occ - OCC_W'(1);
        end
    end

    // One stage per cycle of latency; each dequeue travels as its own bit so pulses never merge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crd_pipe <= '0;
        end else begin
            crd_pipe[0] <= deq;
            for (int i = 1; i < CREDIT_LAT; i++)
                crd_pipe[i] <= crd_pipe[i-1];
        end
    end

`ifdef FCC_OVF_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf_err_o <= 1'b0;
        else if (drop)
            ovf_err_o <= 1'b1;
    end

`ifndef SYNTHESIS
    ovf_chk: assert property (@(posedge clk) disable iff (!rst) !drop)
        else $warning("fcc_credit_return: write to full buffer dropped");
`endif
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule
